ram_tdp_be: RTL and testbench

- True dual-port synchronous RAM with byte-write enables on both ports.
- Selectable same-port read-during-write mode and optional output pipeline register.
- Optional post-reset memory clear sequence.
- General on-chip buffer for DMA and packet paths. Successor to the single-clock dual-port RAM: adds data-valid tracking, defined collision arbitration and a collision flag.

---
 rtl/ram_tdp_be.sv | 173 +++++++++++++++++
 tb/tb_ram_tdp_be.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_tdp_be.sv
// True dual-port RAM with byte enables, collision flag and optional
// post-reset clear sweep; port A wins byte-level write/write conflicts.
module ram_tdp_be #(
   parameter  int DATA_WIDTH = 32,
   parameter  int DEPTH      = 16,
   parameter  int RD_MODE    = 0,
   parameter  int OUT_REG    = 0,
   parameter  int CLR_ON_RST = 1,
   localparam int ADDR_WIDTH = $clog2(DEPTH),
   localparam int BWEN_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic                  cen,
   output logic                  init_done,
   input  logic                  en_a,
   input  logic                  wen_a,
   input  logic [BWEN_WIDTH-1:0] bwen_a,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [DATA_WIDTH-1:0] din_a,
   output logic [DATA_WIDTH-1:0] dout_a,
   output logic                  dvld_a,
   input  logic                  en_b,
   input  logic                  wen_b,
   input  logic [BWEN_WIDTH-1:0] bwen_b,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic [DATA_WIDTH-1:0] din_b,
   output logic [DATA_WIDTH-1:0] dout_b,
   output logic                  dvld_b,
   output logic                  collision
);

   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   LIM  = (ADDR_WIDTH + 1)'(DEPTH);

   typedef enum logic {
      S_INIT,
      S_RUN
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  init_done_q, init_done_d;
   logic                  init_wr;
   logic                  collision_q, collision_d;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  act;
   logic [1:0]            en, wr, ok, acc;
   logic [ADDR_WIDTH-1:0] addr [2];
   logic [DATA_WIDTH-1:0] din  [2];
   logic [BWEN_WIDTH-1:0] bw   [2];
   logic [BWEN_WIDTH-1:0] be   [2];
   logic [DATA_WIDTH-1:0] old  [2];
   logic [DATA_WIDTH-1:0] rdat [2];

   logic [1:0]            s1_v_q, dvld_q;
   logic [DATA_WIDTH-1:0] s1_d_q [2];
   logic [DATA_WIDTH-1:0] dout_q [2];

   assign en      = {en_b, en_a};
   assign wr      = {wen_b, wen_a};
   assign addr[0] = addr_a;
   assign addr[1] = addr_b;
   assign din[0]  = din_a;
   assign din[1]  = din_b;
   assign bw[0]   = bwen_a;
   assign bw[1]   = bwen_b;

   // accesses only once the clear sweep has finished
   assign act = init_done_q & cen;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      init_done_d = (state_q == S_RUN);
      init_wr     = 1'b0;
      unique case (state_q)
         S_INIT: begin
            init_wr = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d     = S_RUN;
               cnt_d       = '0;
               init_done_d = 1'b1;
            end
         end
         S_RUN: begin
         end
         default: state_d = S_RUN;
      endcase
   end

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         ok[p]   = ({1'b0, addr[p]} < LIM);
         acc[p]  = act & en[p];
         be[p]   = (acc[p] & wr[p] & ok[p]) ? bw[p] : '0;
         old[p]  = ok[p] ? mem[addr[p]] : '0;
         rdat[p] = old[p];
         if (RD_MODE != 0) begin
            for (int i = 0; i < BWEN_WIDTH; i++) begin
               if (be[p][i]) rdat[p][8*i +: 8] = din[p][8*i +: 8];
            end
         end
      end
   end

   assign collision_d = act & en_a & en_b & (addr_a == addr_b) & (wen_a | wen_b);

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= (CLR_ON_RST != 0) ? S_INIT : S_RUN;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
         collision_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_done_q <= init_done_d;
         collision_q <= collision_d;
      end
   end

   // port B is applied first so port A's bytes override on overlap
   always_ff @(posedge clock) begin
      if (init_wr) begin
         mem[cnt_q] <= '0;
      end else begin
         for (int p = 1; p >= 0; p--) begin
            for (int i = 0; i < BWEN_WIDTH; i++) begin
               if (be[p][i]) mem[addr[p]][8*i +: 8] <= din[p][8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q <= '0;
         dvld_q <= '0;
         for (int p = 0; p < 2; p++) begin
            s1_d_q[p] <= '0;
            dout_q[p] <= '0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (OUT_REG != 0) begin
               if (cen) begin
                  s1_v_q[p] <= acc[p];
                  if (acc[p]) s1_d_q[p] <= rdat[p];
                  dvld_q[p] <= s1_v_q[p];
                  if (s1_v_q[p]) dout_q[p] <= s1_d_q[p];
               end else begin
                  dvld_q[p] <= 1'b0;
               end
            end else begin
               dvld_q[p] <= acc[p];
               if (acc[p]) dout_q[p] <= rdat[p];
            end
         end
      end
   end

   assign init_done = init_done_q;
   assign collision = collision_q;
   assign dout_a    = dout_q[0];
   assign dout_b    = dout_q[1];
   assign dvld_a    = dvld_q[0];
   assign dvld_b    = dvld_q[1];

endmodule

// File: tb/tb_ram_tdp_be.sv
// Directed bench: d0 = defaults (DEPTH 16, read-first, latency 1),
// d1 = DEPTH 12, write-first, latency 2; both share the same stimulus.
module tb_ram_tdp_be;

   logic        clock = 1'b0;
   logic        rst_n, cen;
   logic        en_a, wen_a, en_b, wen_b;
   logic [3:0]  bwen_a, bwen_b, addr_a, addr_b;
   logic [31:0] din_a, din_b;

   logic        init_done0, dvld_a0, dvld_b0, coll0;
   logic [31:0] dout_a0, dout_b0;
   logic        init_done1, dvld_a1, dvld_b1, coll1;
   logic [31:0] dout_a1, dout_b1;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   ram_tdp_be d0 (
      .clock(clock), .rst_n(rst_n), .cen(cen), .init_done(init_done0),
      .en_a(en_a), .wen_a(wen_a), .bwen_a(bwen_a), .addr_a(addr_a),
      .din_a(din_a), .dout_a(dout_a0), .dvld_a(dvld_a0),
      .en_b(en_b), .wen_b(wen_b), .bwen_b(bwen_b), .addr_b(addr_b),
      .din_b(din_b), .dout_b(dout_b0), .dvld_b(dvld_b0),
      .collision(coll0)
   );

   ram_tdp_be #(.DEPTH(12), .RD_MODE(1), .OUT_REG(1)) d1 (
      .clock(clock), .rst_n(rst_n), .cen(cen), .init_done(init_done1),
      .en_a(en_a), .wen_a(wen_a), .bwen_a(bwen_a), .addr_a(addr_a),
      .din_a(din_a), .dout_a(dout_a1), .dvld_a(dvld_a1),
      .en_b(en_b), .wen_b(wen_b), .bwen_b(bwen_b), .addr_b(addr_b),
      .din_b(din_b), .dout_b(dout_b1), .dvld_b(dvld_b1),
      .collision(coll1)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      en_a = 0; wen_a = 0; bwen_a = 0; addr_a = 0; din_a = 0;
      en_b = 0; wen_b = 0; bwen_b = 0; addr_b = 0; din_b = 0;
   endtask

   task automatic setp(input bit p, input bit w, input logic [3:0] be,
                       input logic [3:0] ad, input logic [31:0] d);
      if (!p) begin
         en_a = 1; wen_a = w; bwen_a = be; addr_a = ad; din_a = d;
      end else begin
         en_b = 1; wen_b = w; bwen_b = be; addr_b = ad; din_b = d;
      end
   endtask

   task automatic wr(input bit p, input logic [3:0] ad,
                     input logic [3:0] be, input logic [31:0] d);
      idle();
      setp(p, 1'b1, be, ad, d);
      cyc();
      idle();
      cyc();
      cyc();
   endtask

   task automatic rd_chk(input string tag, input bit p, input logic [3:0] ad,
                         input logic [31:0] e0, input logic [31:0] e1);
      idle();
      setp(p, 1'b0, 4'h0, ad, 32'h0);
      cyc();
      idle();
      check({tag, "_d0"}, p ? dout_b0 : dout_a0, e0);
      check({tag, "_v0"}, 32'(p ? dvld_b0 : dvld_a0), 32'd1);
      cyc();
      check({tag, "_d1"}, p ? dout_b1 : dout_a1, e1);
      check({tag, "_v1"}, 32'(p ? dvld_b1 : dvld_a1), 32'd1);
      check({tag, "_v0off"}, 32'(p ? dvld_b0 : dvld_a0), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0;
      cen   = 1;
      idle();
      cyc();
      cyc();
      check("rst_dout_a0", dout_a0, 0);
      check("rst_dout_b1", dout_b1, 0);
      check("rst_dvld", 32'({dvld_a0, dvld_b0, dvld_a1, dvld_b1}), 0);
      check("rst_coll", 32'({coll0, coll1}), 0);
      check("rst_init", 32'({init_done0, init_done1}), 0);

      rst_n = 1;
      for (int n = 1; n <= 16; n++) begin
         idle();
         if (n <= 11) setp(1'b0, 1'b0, 4'h0, 4'(n), 32'h0);
         cyc();
         check("init_done0", 32'(init_done0), 32'(n >= 16));
         check("init_done1", 32'(init_done1), 32'(n >= 12));
         check("init_nodvld", 32'({dvld_a0, dvld_a1}), 0);
      end
      idle();

      for (int a = 0; a < 16; a++) rd_chk("clr", 1'b0, 4'(a), 0, 0);

      wr(1'b0, 4'd3, 4'hF, 32'hDEADBEEF);
      rd_chk("wr3_rdB", 1'b1, 4'd3, 32'hDEADBEEF, 32'hDEADBEEF);

      wr(1'b0, 4'd5, 4'hF, 32'h11223344);
      setp(1'b0, 1'b1, 4'b0101, 4'd5, 32'hAABBCCDD);
      cyc();
      idle();
      check("rdw_old_d0", dout_a0, 32'h11223344);
      cyc();
      check("rdw_new_d1", dout_a1, 32'h11BB33DD);
      rd_chk("rdw_mem", 1'b0, 4'd5, 32'h11BB33DD, 32'h11BB33DD);

      wr(1'b0, 4'd7, 4'hF, 32'h12345678);
      setp(1'b0, 1'b1, 4'b0011, 4'd7, 32'hAAAAAAAA);
      setp(1'b1, 1'b1, 4'b0110, 4'd7, 32'hBBBBBBBB);
      cyc();
      idle();
      check("ww_coll", 32'({coll0, coll1}), 32'b11);
      check("ww_old_a0", dout_a0, 32'h12345678);
      check("ww_old_b0", dout_b0, 32'h12345678);
      cyc();
      check("ww_coll_off", 32'({coll0, coll1}), 0);
      check("ww_own_a1", dout_a1, 32'h1234AAAA);
      cyc();
      rd_chk("ww_mem", 1'b1, 4'd7, 32'h12BBAAAA, 32'h12BBAAAA);

      wr(1'b1, 4'd2, 4'hF, 32'h00000077);
      setp(1'b0, 1'b0, 4'h0, 4'd2, 32'h0);
      setp(1'b1, 1'b1, 4'hF, 4'd2, 32'h00000005);
      cyc();
      idle();
      check("rw_old_a0", dout_a0, 32'h77);
      check("rw_coll", 32'({coll0, coll1}), 32'b11);
      cyc();
      check("rw_old_a1", dout_a1, 32'h77);
      check("rw_coll_off", 32'({coll0, coll1}), 0);
      cyc();
      rd_chk("rw_mem", 1'b0, 4'd2, 32'h5, 32'h5);

      setp(1'b0, 1'b1, 4'h0, 4'd5, 32'hFFFFFFFF);
      cyc();
      idle();
      check("bw0_coll", 32'(coll0), 0);
      cyc();
      cyc();
      rd_chk("bw0_mem", 1'b0, 4'd5, 32'h11BB33DD, 32'h11BB33DD);

      wr(1'b0, 4'd13, 4'hF, 32'hCAFEF00D);
      rd_chk("oor", 1'b1, 4'd13, 32'hCAFEF00D, 32'h0);

      setp(1'b0, 1'b0, 4'h0, 4'd3, 32'h0);
      cyc();
      check("cen_pre_v0", 32'(dvld_a0), 1);
      cen = 0;
      idle();
      setp(1'b0, 1'b1, 4'hF, 4'd3, 32'h0);
      setp(1'b1, 1'b1, 4'hF, 4'd3, 32'h1);
      cyc();
      check("cen0_v1", 32'(dvld_a1), 0);
      check("cen0_v0", 32'(dvld_a0), 0);
      check("cen0_coll", 32'({coll0, coll1}), 0);
      cyc();
      check("cen0_v1b", 32'(dvld_a1), 0);
      cen = 1;
      idle();
      cyc();
      check("cen1_v1", 32'(dvld_a1), 1);
      check("cen1_d1", dout_a1, 32'hDEADBEEF);
      cyc();
      check("cen1_v1off", 32'(dvld_a1), 0);
      check("cen1_hold", dout_a1, 32'hDEADBEEF);
      rd_chk("cen_nowr", 1'b0, 4'd3, 32'hDEADBEEF, 32'hDEADBEEF);

      setp(1'b0, 1'b0, 4'h0, 4'd5, 32'h0);
      cyc();
      idle();
      cen = 0;
      cyc();
      cyc();
      check("prerst_v1", 32'(dvld_a1), 0);
      rst_n = 0;
      #1;
      check("mrst_dout", dout_a0 | dout_a1, 0);
      check("mrst_dvld", 32'({dvld_a0, dvld_a1}), 0);
      check("mrst_coll", 32'({coll0, coll1}), 0);
      check("mrst_init", 32'({init_done0, init_done1}), 0);
      cen = 1;
      cyc();
      cyc();
      rst_n = 1;
      setp(1'b0, 1'b1, 4'hF, 4'd5, 32'hFFFFFFFF);
      for (int n = 1; n <= 16; n++) begin
         cyc();
         idle();
         check("mrst_nodvld", 32'({dvld_a0, dvld_a1}), 0);
      end
      check("mrst_done", 32'({init_done0, init_done1}), 32'b11);
      rd_chk("mrst_clr", 1'b0, 4'd5, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
